timer_register_mc: RTL and testbench

Parametrised register file for the multi-channel timer. Connects a simple enable/write bus to the counter core. Adds the following over the single-generation block:
- N compare channels.
- Sticky write-1-to-clear status flags.
- Per-channel interrupt enables with a registered irq output.
- Shadow (preload) copies of compare/min/max, committed on a counter update event.
- Registered read data and an error pulse for bad addresses.

---
 rtl/timer_register_mc.sv | 187 ++++++++++++++++++
 tb/tb_timer_register_mc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/timer_register_mc.sv
// rtl/timer_register_mc.sv - multi-channel timer register file
// Shadowed limits/compares, sticky W1C status flags, registered irq and read data.
module timer_register_mc #(
  parameter int COUNTER_BIT_WIDTH = 16,
  parameter int NUM_CMP           = 4,
  parameter int PRESCALER_BITS    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 write_enable,
  input  logic [3:0]                           address,
  input  logic [COUNTER_BIT_WIDTH-1:0]         write_data,
  output logic [COUNTER_BIT_WIDTH-1:0]         read_data,
  output logic                                 bus_err,
  input  logic                                 update_evt,
  input  logic [NUM_CMP-1:0]                   cmp_f,
  input  logic [COUNTER_BIT_WIDTH-1:0]         count,
  output logic [PRESCALER_BITS-1:0]            prescaler,
  output logic                                 start,
  output logic                                 count_mode,
  output logic                                 clock_selector,
  output logic [COUNTER_BIT_WIDTH-1:0]         count_min,
  output logic [COUNTER_BIT_WIDTH-1:0]         count_max,
  output logic [NUM_CMP*COUNTER_BIT_WIDTH-1:0] cmp_value,
  output logic                                 irq
);
  localparam int W = COUNTER_BIT_WIDTH;
  localparam int P = PRESCALER_BITS;
  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_COUNT  = 4'd2;
  localparam logic [3:0] ADDR_MIN    = 4'd3;
  localparam logic [3:0] ADDR_MAX    = 4'd4;
  localparam logic [3:0] ADDR_INTEN  = 4'd5;
  localparam logic [3:0] ADDR_LIMIT  = 4'(6 + NUM_CMP);

  logic [P-1:0]         prescaler_q, prescaler_d;
  logic                 start_q, start_d, count_mode_q, count_mode_d;
  logic                 clock_selector_q, clock_selector_d, preload_en_q, preload_en_d;
  logic [NUM_CMP-1:0]   flags_q, flags_d, int_en_q, int_en_d;
  logic [W-1:0]         min_sh_q, min_sh_d, max_sh_q, max_sh_d;
  logic [W-1:0]         min_act_q, min_act_d, max_act_q, max_act_d;
  logic [NUM_CMP*W-1:0] cmp_sh_q, cmp_sh_d, cmp_act_q, cmp_act_d;
  logic                 irq_q, irq_d, bus_err_q, bus_err_d;
  logic [W-1:0]         read_data_q, read_data_d;

  logic         mapped, wr_acc, rd_acc, commit;
  logic [W-1:0] ctrl_rd, rd_val;

  always_comb begin
    mapped = address < ADDR_LIMIT;
    wr_acc = enable && write_enable && mapped;
    rd_acc = enable && !write_enable && mapped;
    commit = (update_evt && preload_en_q) ||
             (wr_acc && address == ADDR_CTRL && write_data[P+4]);

    ctrl_rd        = '0;
    ctrl_rd[P-1:0] = prescaler_q;
    ctrl_rd[P]     = start_q;
    ctrl_rd[P+1]   = count_mode_q;
    ctrl_rd[P+2]   = clock_selector_q;
    ctrl_rd[P+3]   = preload_en_q;

    prescaler_d      = prescaler_q;
    start_d          = start_q;
    count_mode_d     = count_mode_q;
    clock_selector_d = clock_selector_q;
    preload_en_d     = preload_en_q;
    int_en_d         = int_en_q;
    min_sh_d         = min_sh_q;
    max_sh_d         = max_sh_q;
    cmp_sh_d         = cmp_sh_q;
    min_act_d        = min_act_q;
    max_act_d        = max_act_q;
    cmp_act_d        = cmp_act_q;

    // Commit reads the pre-write shadow; a direct (non-preload) write overrides afterwards.
    if (commit) begin
      min_act_d = min_sh_q;
      max_act_d = max_sh_q;
      cmp_act_d = cmp_sh_q;
    end

    if (wr_acc) begin
      case (address)
        ADDR_CTRL: begin
          prescaler_d      = write_data[P-1:0];
          start_d          = write_data[P];
          count_mode_d     = write_data[P+1];
          clock_selector_d = write_data[P+2];
          preload_en_d     = write_data[P+3];
        end
        ADDR_MIN: begin
          min_sh_d = write_data;
          if (!preload_en_q) min_act_d = write_data;
        end
        ADDR_MAX: begin
          max_sh_d = write_data;
          if (!preload_en_q) max_act_d = write_data;
        end
        ADDR_INTEN: int_en_d = write_data[NUM_CMP-1:0];
        default: ;
      endcase
      for (int k = 0; k < NUM_CMP; k++) begin
        if (address == 4'(6 + k)) begin
          cmp_sh_d[k*W +: W] = write_data;
          if (!preload_en_q) cmp_act_d[k*W +: W] = write_data;
        end
      end
    end

    // New compare matches win over a simultaneous W1C clear.
    flags_d = flags_q | cmp_f;
    if (wr_acc && address == ADDR_STATUS)
      flags_d = (flags_q & ~write_data[NUM_CMP-1:0]) | cmp_f;
    irq_d = |(flags_q & int_en_q);

    rd_val = '0;
    case (address)
      ADDR_CTRL:   rd_val = ctrl_rd;
      ADDR_STATUS: rd_val = W'(flags_q);
      ADDR_COUNT:  rd_val = count;
      ADDR_MIN:    rd_val = min_sh_q;
      ADDR_MAX:    rd_val = max_sh_q;
      ADDR_INTEN:  rd_val = W'(int_en_q);
      default: begin
        for (int k = 0; k < NUM_CMP; k++)
          if (address == 4'(6 + k)) rd_val = cmp_sh_q[k*W +: W];
      end
    endcase

    read_data_d = read_data_q;
    if (rd_acc) read_data_d = rd_val;
    else if (enable) read_data_d = '0;
    bus_err_d = enable && !mapped;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q      <= '0;
      start_q          <= 1'b0;
      count_mode_q     <= 1'b0;
      clock_selector_q <= 1'b0;
      preload_en_q     <= 1'b0;
      flags_q          <= '0;
      int_en_q         <= '0;
      min_sh_q         <= '0;
      max_sh_q         <= '1;
      cmp_sh_q         <= '0;
      min_act_q        <= '0;
      max_act_q        <= '1;
      cmp_act_q        <= '0;
      irq_q            <= 1'b0;
      bus_err_q        <= 1'b0;
      read_data_q      <= '0;
    end else begin
      prescaler_q      <= prescaler_d;
      start_q          <= start_d;
      count_mode_q     <= count_mode_d;
      clock_selector_q <= clock_selector_d;
      preload_en_q     <= preload_en_d;
      flags_q          <= flags_d;
      int_en_q         <= int_en_d;
      min_sh_q         <= min_sh_d;
      max_sh_q         <= max_sh_d;
      cmp_sh_q         <= cmp_sh_d;
      min_act_q        <= min_act_d;
      max_act_q        <= max_act_d;
      cmp_act_q        <= cmp_act_d;
      irq_q            <= irq_d;
      bus_err_q        <= bus_err_d;
      read_data_q      <= read_data_d;
    end
  end

  assign prescaler      = prescaler_q;
  assign start          = start_q;
  assign count_mode     = count_mode_q;
  assign clock_selector = clock_selector_q;
  assign count_min      = min_act_q;
  assign count_max      = max_act_q;
  assign cmp_value      = cmp_act_q;
  assign irq            = irq_q;
  assign bus_err        = bus_err_q;
  assign read_data      = read_data_q;
endmodule

// File: tb/tb_timer_register_mc.sv
// tb/tb_timer_register_mc.sv - directed self-checking bench for timer_register_mc
module tb_timer_register_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, write_enable = 1'b0, update_evt = 1'b0;
  logic [3:0]  address = '0;
  logic [15:0] write_data = '0, count = '0;
  logic [3:0]  cmp_f = '0;
  logic [15:0] read_data, count_min, count_max;
  logic        bus_err, start, count_mode, clock_selector, irq;
  logic [2:0]  prescaler;
  logic [63:0] cmp_value;
  int checks = 0;
  int failures = 0;
  logic [15:0] rd;

  timer_register_mc #(.COUNTER_BIT_WIDTH(16), .NUM_CMP(4), .PRESCALER_BITS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data),
    .bus_err(bus_err), .update_evt(update_evt), .cmp_f(cmp_f), .count(count),
    .prescaler(prescaler), .start(start), .count_mode(count_mode),
    .clock_selector(clock_selector), .count_min(count_min), .count_max(count_max),
    .cmp_value(cmp_value), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    enable = 1'b1; write_enable = 1'b1; address = a; write_data = d;
    tick();
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    enable = 1'b1; write_enable = 1'b0; address = a;
    tick();
    d = read_data;
    enable = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_cmp_value", cmp_value, 64'h0);
    check("rst_count_max", count_max, 16'hFFFF);
    check("rst_irq", irq, 1'b0);
    check("rst_read_data", read_data, 16'h0);
    check("rst_bus_err", bus_err, 1'b0);
    rst = 1'b1;
    tick();
    bus_read(4'd4, rd);
    check("rst_read_max_shadow", rd, 16'hFFFF);

    // direct write path
    bus_write(4'd8, 16'h1234);
    check("direct_cmp2_active", cmp_value[47:32], 16'h1234);
    bus_read(4'd8, rd);
    check("direct_cmp2_read", rd, 16'h1234);

    // preload path with overlapping write
    bus_write(4'd0, 16'h0040);
    bus_write(4'd6, 16'h0050);
    check("preload_cmp0_held", cmp_value[15:0], 16'h0000);
    bus_read(4'd6, rd);
    check("preload_cmp0_shadow_read", rd, 16'h0050);
    update_evt = 1'b1; tick(); update_evt = 1'b0;
    check("preload_cmp0_commit", cmp_value[15:0], 16'h0050);
    update_evt = 1'b1;
    bus_write(4'd6, 16'h0060);
    update_evt = 1'b0;
    check("overlap_cmp0_old_shadow", cmp_value[15:0], 16'h0050);
    update_evt = 1'b1; tick(); update_evt = 1'b0;
    check("overlap_cmp0_next_commit", cmp_value[15:0], 16'h0060);
    bus_write(4'd3, 16'h0011);
    check("preload_min_held", count_min, 16'h0000);
    update_evt = 1'b1; tick(); update_evt = 1'b0;
    check("preload_min_commit", count_min, 16'h0011);

    // interrupt path
    bus_write(4'd5, 16'h0002);
    cmp_f = 4'b0011; tick(); cmp_f = 4'b0000;
    check("irq_after_edge1", irq, 1'b0);
    tick();
    check("irq_after_edge2", irq, 1'b1);
    bus_read(4'd1, rd);
    check("status_both_set", rd, 16'h0003);
    bus_write(4'd1, 16'h0002);
    tick();
    check("irq_cleared", irq, 1'b0);
    bus_read(4'd1, rd);
    check("status_after_w1c", rd, 16'h0001);

    // set beats clear
    cmp_f = 4'b0010; tick(); cmp_f = 4'b0000;
    tick();
    check("irq_reasserted", irq, 1'b1);
    cmp_f = 4'b0010;
    bus_write(4'd1, 16'h0002);
    cmp_f = 4'b0000;
    tick();
    check("set_wins_irq", irq, 1'b1);
    bus_read(4'd1, rd);
    check("set_wins_status", rd, 16'h0003);

    // COUNT read and ignored COUNT write
    count = 16'hABCD;
    bus_write(4'd2, 16'h5555);
    check("count_write_no_err", bus_err, 1'b0);
    bus_read(4'd2, rd);
    check("count_read", rd, 16'hABCD);

    // unmapped accesses
    bus_write(4'd10, 16'hBEEF);
    check("unmapped_wr_err", bus_err, 1'b1);
    tick();
    check("unmapped_err_one_cycle", bus_err, 1'b0);
    check("unmapped_wr_no_change", cmp_value, 64'h0000_1234_0000_0060);
    bus_read(4'd15, rd);
    check("unmapped_rd_data", rd, 16'h0000);
    check("unmapped_rd_err", bus_err, 1'b1);

    // forced commit via CTRL
    bus_write(4'd6, 16'h0070);
    check("force_pre_cmp0", cmp_value[15:0], 16'h0060);
    bus_write(4'd0, 16'h00C5);
    check("force_commit_cmp0", cmp_value[15:0], 16'h0070);
    check("ctrl_prescaler", prescaler, 3'd5);
    bus_read(4'd0, rd);
    check("ctrl_readback_no_force", rd, 16'h0045);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
